// File: rtl/i2s_codec_master.sv
// I2S master for an audio codec: generates AUD_BCLK and the word clocks, serializes
// tx sample pairs onto AUD_ADCDAT and deserializes AUD_DACDAT into rx sample pairs.
module i2s_codec_master #(
  parameter int BCLK_DIV    = 16,
  parameter int SAMPLE_BITS = 32
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic [SAMPLE_BITS-1:0] tx_left,
  input  logic [SAMPLE_BITS-1:0] tx_right,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [SAMPLE_BITS-1:0] rx_left,
  output logic [SAMPLE_BITS-1:0] rx_right,
  output logic                   rx_valid,
  output logic                   underrun,
  output logic                   AUD_BCLK,
  output logic                   AUD_ADCLRCK,
  output logic                   AUD_DACLRCK,
  output logic                   AUD_ADCDAT,
  input  logic                   AUD_DACDAT
);

  localparam int FW = 2 * SAMPLE_BITS;
  localparam int DW = $clog2(BCLK_DIV);
  localparam int SW = $clog2(FW);
  localparam logic [DW-1:0] DIV_TOP    = DW'(BCLK_DIV - 1);
  localparam logic [SW-1:0] SLOT_TOP   = SW'(FW - 1);
  localparam logic [SW-1:0] SLOT_LOAD  = SW'(1);
  localparam logic [SW-1:0] SLOT_RIGHT = SW'(SAMPLE_BITS);

  // tx handshake: a pair transfers on any cycle where tx_valid and tx_ready are both high.
  logic [DW-1:0]          div_cnt;
  logic [SW-1:0]          slot;
  logic [SW-1:0]          slot_next;
  logic                   lrck;
  logic [FW-1:0]          tx_shift;
  logic [FW-1:0]          rx_shift;
  logic [SAMPLE_BITS-1:0] hold_left;
  logic [SAMPLE_BITS-1:0] hold_right;
  logic                   hold_full;
  logic                   rx_frame_ok;
  logic                   tick;
  logic                   fall;
  logic                   rise;
  logic                   accept;

  always_comb begin
    tick      = (div_cnt == DIV_TOP);
    fall      = tick & AUD_BCLK;
    rise      = tick & ~AUD_BCLK;
    accept    = tx_valid & tx_ready;
    slot_next = (slot == SLOT_TOP) ? '0 : slot + SW'(1);
  end

  assign AUD_ADCLRCK = lrck;
  assign AUD_DACLRCK = lrck;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      div_cnt     <= '0;
      AUD_BCLK    <= 1'b0;
      slot        <= SLOT_TOP;
      lrck        <= 1'b1;
      AUD_ADCDAT  <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      hold_left   <= '0;
      hold_right  <= '0;
      hold_full   <= 1'b0;
      tx_ready    <= 1'b1;
      rx_left     <= '0;
      rx_right    <= '0;
      rx_valid    <= 1'b0;
      underrun    <= 1'b0;
      rx_frame_ok <= 1'b0;
    end else begin
      underrun <= 1'b0;
      rx_valid <= 1'b0;
      div_cnt  <= tick ? '0 : div_cnt + DW'(1);
      if (tick) AUD_BCLK <= ~AUD_BCLK;

      // A pair accepted in the load cycle itself misses that frame and waits for the next.
      if (accept) begin
        hold_left  <= tx_left;
        hold_right <= tx_right;
        hold_full  <= 1'b1;
        tx_ready   <= 1'b0;
      end

      if (fall) begin
        slot <= slot_next;
        lrck <= (slot_next >= SLOT_RIGHT);
        if (slot_next == SLOT_LOAD) begin
          if (hold_full) begin
            AUD_ADCDAT <= hold_left[SAMPLE_BITS-1];
            tx_shift   <= {hold_left, hold_right} << 1;
            hold_full  <= 1'b0;
            tx_ready   <= 1'b1;
          end else begin
            AUD_ADCDAT <= 1'b0;
            tx_shift   <= '0;
            underrun   <= 1'b1;
          end
        end else begin
          AUD_ADCDAT <= tx_shift[FW-1];
          tx_shift   <= tx_shift << 1;
        end
      end

      // The rise in slot 0 delivers the last (right LSB) bit of the frame.
      if (rise) begin
        rx_shift <= {rx_shift[FW-2:0], AUD_DACDAT};
        if (slot == SLOT_LOAD) rx_frame_ok <= 1'b1;
        if (slot == '0 && rx_frame_ok) begin
          rx_left  <= rx_shift[FW-2:SAMPLE_BITS-1];
          rx_right <= {rx_shift[SAMPLE_BITS-2:0], AUD_DACDAT};
          rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_codec_master.sv
// Bench for i2s_codec_master: default instance for frame-level behaviour, a BCLK_DIV=2
// instance for reset-to-first-edge timing.
module tb_i2s_codec_master;

  localparam int DIV   = 16;
  localparam int SB    = 32;
  localparam int FW    = 2 * SB;
  localparam int FRAME = 2 * DIV * FW;

  // clock / reset
  logic CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;
  logic reset   = 1'b1;
  logic b_reset = 1'b1;

  logic [SB-1:0] tx_left  = '0;
  logic [SB-1:0] tx_right = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [SB-1:0] rx_left, rx_right;
  logic          rx_valid, underrun;
  logic          AUD_BCLK, AUD_ADCLRCK, AUD_DACLRCK, AUD_ADCDAT, AUD_DACDAT;
  logic          loop_en = 1'b0;
  logic          src_bit = 1'b0;
  assign AUD_DACDAT = loop_en ? AUD_ADCDAT : src_bit;

  logic [SB-1:0] b_rx_left, b_rx_right;
  logic          b_tx_ready, b_rx_valid, b_underrun;
  logic          b_bclk, b_adclrck, b_daclrck, b_adcdat;

  i2s_codec_master dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .tx_left(tx_left), .tx_right(tx_right), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_left(rx_left), .rx_right(rx_right), .rx_valid(rx_valid), .underrun(underrun),
    .AUD_BCLK(AUD_BCLK), .AUD_ADCLRCK(AUD_ADCLRCK), .AUD_DACLRCK(AUD_DACLRCK),
    .AUD_ADCDAT(AUD_ADCDAT), .AUD_DACDAT(AUD_DACDAT)
  );

  i2s_codec_master #(.BCLK_DIV(2), .SAMPLE_BITS(SB)) dut_fast (
    .CLOCK_50(CLOCK_50), .reset(b_reset),
    .tx_left(32'h0), .tx_right(32'h0), .tx_valid(1'b0), .tx_ready(b_tx_ready),
    .rx_left(b_rx_left), .rx_right(b_rx_right), .rx_valid(b_rx_valid), .underrun(b_underrun),
    .AUD_BCLK(b_bclk), .AUD_ADCLRCK(b_adclrck), .AUD_DACLRCK(b_daclrck),
    .AUD_ADCDAT(b_adcdat), .AUD_DACDAT(1'b0)
  );

  int errors = 0;
  int checks = 0;
  logic [FW-1:0] exp_q[$];

  // bench-side view of the bit clock, slot position and captured AUD_ADCDAT frame
  logic          prev_bclk = 1'b0;
  int            tb_slot = FW - 1;
  logic          rise_seen = 1'b0, fall_seen = 1'b0, frame_done = 1'b0, cap_armed = 1'b0;
  logic [FW-1:0] cap = '0;
  logic [FW-1:0] src_frame = '0;

  task automatic step();
    @(negedge CLOCK_50);
    rise_seen  = AUD_BCLK && !prev_bclk;
    fall_seen  = !AUD_BCLK && prev_bclk;
    prev_bclk  = AUD_BCLK;
    frame_done = 1'b0;
    if (fall_seen) begin
      tb_slot = (tb_slot + 1) % FW;
      src_bit = src_frame[(FW - tb_slot) % FW];
    end
    if (rise_seen) begin
      cap = {cap[FW-2:0], AUD_ADCDAT};
      if (tb_slot == 1) cap_armed = 1'b1;
      if (tb_slot == 0 && cap_armed) frame_done = 1'b1;
    end
  endtask

  task automatic restart_tracking();
    tb_slot    = FW - 1;
    prev_bclk  = 1'b0;
    cap        = '0;
    cap_armed  = 1'b0;
    frame_done = 1'b0;
    rise_seen  = 1'b0;
    fall_seen  = 1'b0;
    src_bit    = src_frame[1];
    exp_q.delete();
  endtask

  task automatic apply_reset();
    tx_valid = 1'b0;
    reset = 1'b1;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
    restart_tracking();
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    int rise_at, fall_at;
    tx_valid = 1'b0;
    reset = 1'b1;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    obs = {AUD_BCLK, AUD_ADCLRCK, AUD_DACLRCK, AUD_ADCDAT, tx_ready, rx_valid, underrun};
    checks++;
    if (obs !== 7'b0110100) begin errors++; $display("FAIL reset_outputs: got %b want %b", obs, 7'b0110100); end
    checks++;
    if ({rx_left, rx_right} !== '0) begin errors++; $display("FAIL reset_rx: got %h want 0", {rx_left, rx_right}); end
    reset = 1'b0;
    restart_tracking();
    rise_at = -1;
    fall_at = -1;
    for (int n = 1; n <= 3 * DIV; n++) begin
      step();
      if (rise_seen && rise_at < 0) rise_at = n;
      if (fall_seen && fall_at < 0) begin
        fall_at = n;
        checks++;
        if ({AUD_ADCLRCK, AUD_DACLRCK} !== 2'b00) begin errors++; $display("FAIL lrck_slot0: got %b want 00", {AUD_ADCLRCK, AUD_DACLRCK}); end
      end
    end
    checks++;
    if (rise_at !== DIV) begin errors++; $display("FAIL first_rise: got %0d want %0d", rise_at, DIV); end
    checks++;
    if (fall_at !== 2 * DIV) begin errors++; $display("FAIL first_fall: got %0d want %0d", fall_at, 2 * DIV); end
  endtask

  task automatic test_tx_pattern();
    int ur, lr_bad, got;
    logic [FW-1:0] exp;
    apply_reset();
    tx_left  = 32'hA5A5_0001;
    tx_right = 32'h8000_00FF;
    tx_valid = 1'b1;
    exp_q.push_back({tx_left, tx_right});
    step();
    tx_valid = 1'b0;
    checks++;
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL tx_accept: tx_ready got %b want 0", tx_ready); end
    ur = 0; lr_bad = 0; got = 0;
    for (int n = 0; n < FRAME + 200 && got == 0; n++) begin
      step();
      if (underrun) ur++;
      if (rise_seen && (AUD_ADCLRCK !== 1'(tb_slot >= SB) || AUD_DACLRCK !== 1'(tb_slot >= SB))) lr_bad++;
      if (frame_done) begin
        got = 1;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (cap !== exp) begin errors++; $display("FAIL tx_frame: got %h want %h", cap, exp); end
      end
    end
    checks++;
    if (got !== 1) begin errors++; $display("FAIL tx_frame_timeout: frames %0d want 1", got); end
    checks++;
    if (ur !== 0) begin errors++; $display("FAIL tx_underrun: got %0d want 0", ur); end
    checks++;
    if (lr_bad !== 0) begin errors++; $display("FAIL lrck_pattern: bad rises %0d want 0", lr_bad); end
  endtask

  task automatic test_underrun();
    int ur, first, last, gap_bad, adc_bad;
    apply_reset();
    ur = 0; first = -1; last = -1; gap_bad = 0; adc_bad = 0;
    for (int n = 1; n <= 4 * DIV + 2 * FRAME + 100; n++) begin
      step();
      if (underrun) begin
        if (last >= 0 && n - last != FRAME) gap_bad++;
        if (first < 0) first = n;
        last = n;
        ur++;
      end
      if (rise_seen && AUD_ADCDAT !== 1'b0) adc_bad++;
    end
    checks++;
    if (ur !== 3) begin errors++; $display("FAIL underrun_count: got %0d want 3", ur); end
    checks++;
    if (first !== 4 * DIV) begin errors++; $display("FAIL underrun_first: got %0d want %0d", first, 4 * DIV); end
    checks++;
    if (gap_bad !== 0) begin errors++; $display("FAIL underrun_period: bad gaps %0d want 0", gap_bad); end
    checks++;
    if (adc_bad !== 0) begin errors++; $display("FAIL underrun_data: nonzero bits %0d want 0", adc_bad); end
  endtask

  task automatic test_rx();
    int got, first_at, hold_bad;
    logic [FW-1:0] last, exp;
    src_frame = {32'h1234_5678, 32'hFFFF_0000};
    loop_en = 1'b0;
    apply_reset();
    exp_q.push_back(src_frame);
    exp_q.push_back(src_frame);
    got = 0; first_at = -1; hold_bad = 0; last = '0;
    for (int n = 1; n <= 2 * FRAME + 200; n++) begin
      step();
      if (rx_valid) begin
        got++;
        if (first_at < 0) first_at = n;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if ({rx_left, rx_right} !== exp) begin errors++; $display("FAIL rx_pair: got %h want %h", {rx_left, rx_right}, exp); end
        last = {rx_left, rx_right};
      end else if (got > 0 && {rx_left, rx_right} !== last) hold_bad++;
    end
    checks++;
    if (got !== 2) begin errors++; $display("FAIL rx_count: got %0d want 2", got); end
    checks++;
    if (first_at !== FRAME + 3 * DIV) begin errors++; $display("FAIL rx_first: got %0d want %0d", first_at, FRAME + 3 * DIV); end
    checks++;
    if (hold_bad !== 0) begin errors++; $display("FAIL rx_hold: changes %0d want 0", hold_bad); end
  endtask

  task automatic test_loopback();
    int sent, got, ur;
    logic ready_low, acc;
    logic [FW-1:0] exp;
    apply_reset();
    loop_en = 1'b1;
    sent = 0; got = 0; ur = 0; ready_low = 1'b0;
    tx_left = $urandom; tx_right = $urandom; tx_valid = 1'b1;
    for (int n = 0; n < 5 * FRAME + 200 && got < 4; n++) begin
      acc = tx_valid && tx_ready;
      if (acc) exp_q.push_back({tx_left, tx_right});
      step();
      if (acc) begin
        sent++;
        if (sent < 4) begin tx_left = $urandom; tx_right = $urandom; end
        else tx_valid = 1'b0;
      end
      if (!tx_ready) ready_low = 1'b1;
      if (underrun) ur++;
      if (rx_valid) begin
        got++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if ({rx_left, rx_right} !== exp) begin errors++; $display("FAIL loop_pair: got %h want %h", {rx_left, rx_right}, exp); end
      end
    end
    tx_valid = 1'b0;
    loop_en = 1'b0;
    checks++;
    if (got !== 4) begin errors++; $display("FAIL loop_count: got %0d want 4", got); end
    checks++;
    if (ur !== 0) begin errors++; $display("FAIL loop_underrun: got %0d want 0", ur); end
    checks++;
    if (ready_low !== 1'b1) begin errors++; $display("FAIL loop_ready: low seen %b want 1", ready_low); end
  endtask

  task automatic test_late_valid();
    int got, ur;
    logic [FW-1:0] exp;
    apply_reset();
    repeat (4 * DIV - 1) step();
    tx_left = $urandom; tx_right = $urandom; tx_valid = 1'b1;
    exp_q.push_back('0);
    exp_q.push_back({tx_left, tx_right});
    step();
    tx_valid = 1'b0;
    checks++;
    if (underrun !== 1'b1) begin errors++; $display("FAIL late_underrun: got %b want 1", underrun); end
    checks++;
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL late_held: tx_ready got %b want 0", tx_ready); end
    got = 0; ur = 0;
    for (int n = 0; n < 2 * FRAME + 200 && got < 2; n++) begin
      step();
      if (underrun) ur++;
      if (frame_done) begin
        got++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (cap !== exp) begin errors++; $display("FAIL late_frame%0d: got %h want %h", got, cap, exp); end
      end
    end
    checks++;
    if (got !== 2) begin errors++; $display("FAIL late_count: got %0d want 2", got); end
    checks++;
    if (ur !== 0) begin errors++; $display("FAIL late_extra_underrun: got %0d want 0", ur); end
  endtask

  task automatic test_mid_reset();
    int n, rv, ur, ur_at, adc_bad;
    logic [6:0] obs;
    src_frame = {$urandom, $urandom};
    loop_en = 1'b0;
    apply_reset();
    n = 0;
    while (n < 2 * FRAME && !(n > FRAME && fall_seen && tb_slot == 40)) begin
      step();
      n++;
    end
    checks++;
    if (!(fall_seen && tb_slot == 40)) begin errors++; $display("FAIL mid_reach_slot40: slot %0d want 40", tb_slot); end
    tx_left = $urandom; tx_right = $urandom; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    reset = 1'b1;
    step();
    obs = {AUD_BCLK, AUD_ADCLRCK, AUD_DACLRCK, AUD_ADCDAT, tx_ready, rx_valid, underrun};
    checks++;
    if (obs !== 7'b0110100) begin errors++; $display("FAIL mid_reset_outputs: got %b want %b", obs, 7'b0110100); end
    checks++;
    if ({rx_left, rx_right} !== '0) begin errors++; $display("FAIL mid_reset_rx: got %h want 0", {rx_left, rx_right}); end
    reset = 1'b0;
    restart_tracking();
    rv = 0; ur = 0; ur_at = -1; adc_bad = 0;
    for (int k = 1; k <= 2000; k++) begin
      step();
      if (rx_valid) rv++;
      if (underrun) begin ur++; if (ur_at < 0) ur_at = k; end
      if (rise_seen && AUD_ADCDAT !== 1'b0) adc_bad++;
    end
    checks++;
    if (rv !== 0) begin errors++; $display("FAIL mid_rx_valid: got %0d want 0", rv); end
    checks++;
    if (ur !== 1 || ur_at !== 4 * DIV) begin errors++; $display("FAIL mid_underrun: got %0d at %0d want 1 at %0d", ur, ur_at, 4 * DIV); end
    checks++;
    if (adc_bad !== 0) begin errors++; $display("FAIL mid_discard: nonzero bits %0d want 0", adc_bad); end
  endtask

  task automatic test_fast_div();
    int rise_at, fall_at;
    logic prev;
    logic [6:0] obs;
    b_reset = 1'b1;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    b_reset = 1'b0;
    prev = 1'b0; rise_at = -1; fall_at = -1;
    for (int n = 1; n <= 166; n++) begin
      @(negedge CLOCK_50);
      if (b_bclk && !prev && rise_at < 0) rise_at = n;
      if (!b_bclk && prev && fall_at < 0) fall_at = n;
      prev = b_bclk;
    end
    checks++;
    if (rise_at !== 2 || fall_at !== 4) begin errors++; $display("FAIL fast_first_edges: got %0d/%0d want 2/4", rise_at, fall_at); end
    checks++;
    if ({b_bclk, b_adclrck} !== 2'b11) begin errors++; $display("FAIL fast_slot40: got %b want 11", {b_bclk, b_adclrck}); end
    b_reset = 1'b1;
    @(negedge CLOCK_50);
    obs = {b_bclk, b_adclrck, b_daclrck, b_adcdat, b_tx_ready, b_rx_valid, b_underrun};
    checks++;
    if (obs !== 7'b0110100) begin errors++; $display("FAIL fast_reset_outputs: got %b want %b", obs, 7'b0110100); end
    b_reset = 1'b0;
    prev = 1'b0; fall_at = -1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge CLOCK_50);
      if (!b_bclk && prev && fall_at < 0) fall_at = n;
      prev = b_bclk;
    end
    checks++;
    if (fall_at !== 4) begin errors++; $display("FAIL fast_fall_after_reset: got %0d want 4", fall_at); end
  endtask

  initial begin
    #(200000 * 20);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tx_pattern();
    test_underrun();
    test_rx();
    test_loopback();
    test_late_valid();
    test_mid_reset();
    test_fast_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
